// File: rtl/gate_op_scheduler.sv
// gate_op_scheduler
//   Shares one 2-input logic unit (AND/OR/XOR/NAND) between NUM_REQ
//   requesters. Round-robin arbitration in IDLE, then a fixed
//   GRANT -> EXEC -> RESP sequence returns a tagged result.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           tile enable; low freezes all state and masks pulses
//   req           level request per requester
//   req_data      requester i at [4i+3:4i] = {op[1:0], b, a}
//   gnt           one-hot grant pulse (GRANT state)
//   result        logic-unit result, held until the next RESP
//   result_valid  one-cycle pulse in RESP
//   result_id     index of the requester owning result
//   busy          high whenever the FSM is not in IDLE
//   stat_count    completed-operation count (saturating at 255)
//
// Optional feature: define GATE_OP_STATS_EN to build the stat_count
// counter; otherwise stat_count is tied to zero and no flops exist.

module gate_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 result,
  output logic                 result_valid,
  output logic [ID_W-1:0]      result_id,
  output logic                 busy,
  output logic [7:0]           stat_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [ID_W-1:0]      winner_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 a_q;
  logic                 b_q;
  logic [1:0]           op_q;
  logic                 result_q;
  logic                 valid_q;
  logic [ID_W-1:0]      result_id_q;
  logic                 busy_q;

  logic [ID_W-1:0]      pick_d;
  logic [NUM_REQ-1:0]   onehot_d;
  logic [3:0]           data_d;
  logic                 alu_d;
  logic [ID_W-1:0]      rr_next_d;

  // Round-robin pick: lowest set bit at or above rr_ptr wins; if none,
  // the search wraps and the lowest set bit overall wins.
  logic                 hi_found;
  logic                 lo_found;
  logic [ID_W-1:0]      hi_idx;
  logic [ID_W-1:0]      lo_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (req[j] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(j);
      end
      if (req[j] && !hi_found && (ID_W'(j) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(j);
      end
    end
    pick_d = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    onehot_d = '0;
    data_d   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == pick_d) begin
        onehot_d[j] = 1'b1;
        data_d      = req_data[4*j +: 4];
      end
    end
  end

  always_comb begin
    alu_d = 1'b0;
    case (op_q)
      2'b00:   alu_d = a_q & b_q;
      2'b01:   alu_d = a_q | b_q;
      2'b10:   alu_d = a_q ^ b_q;
      default: alu_d = ~(a_q & b_q);
    endcase
  end

  assign rr_next_d = (winner_q == ID_W'(NUM_REQ - 1)) ? '0 : winner_q + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      gnt_q       <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      op_q        <= '0;
      result_q    <= 1'b0;
      valid_q     <= 1'b0;
      result_id_q <= '0;
      busy_q      <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            winner_q <= pick_d;
            gnt_q    <= onehot_d;
            a_q      <= data_d[0];
            b_q      <= data_d[1];
            op_q     <= data_d[3:2];
            busy_q   <= 1'b1;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          gnt_q   <= '0;
          state_q <= EXEC;
        end
        EXEC: begin
          result_q    <= alu_d;
          result_id_q <= winner_q;
          valid_q     <= 1'b1;
          rr_ptr_q    <= rr_next_d;
          state_q     <= RESP;
        end
        RESP: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pulses are held in their registers while ena is low and only masked
  // at the port, so the owed pulse appears once ena returns.
  assign gnt          = ena ? gnt_q : '0;
  assign result_valid = ena & valid_q;
  assign result       = result_q;
  assign result_id    = result_id_q;
  assign busy         = busy_q;

`ifdef GATE_OP_STATS_EN
  logic [7:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (ena && (state_q == RESP) && (stat_q != 8'hFF)) begin
      stat_q <= stat_q + 8'd1;
    end
  end

  assign stat_count = stat_q;
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed self-checking bench for gate_op_scheduler (NUM_REQ=4, ID_W=2).
// Inputs change 1 ns after the rising edge; outputs are checked there too.

module tb_gate_op_scheduler;

  localparam int NR = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [NR-1:0] req;
  logic [4*NR-1:0] req_data;
  logic [NR-1:0] gnt;
  logic          result;
  logic          result_valid;
  logic [IW-1:0] result_id;
  logic          busy;
  logic [7:0]    stat_count;

  int errors = 0;
  int checks = 0;

  gate_op_scheduler #(
    .NUM_REQ (NR),
    .ID_W    (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .result       (result),
    .result_valid (result_valid),
    .result_id    (result_id),
    .busy         (busy),
    .stat_count   (stat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one operation from the sampling edge through the return to IDLE.
  task automatic service(input int lane, input logic exp_res, input bit drop_req, input string tag);
    logic [NR-1:0] oh;
    oh = NR'(1) << lane;
    tick();
    check({tag, ":gnt"}, 32'(gnt), 32'(oh));
    check({tag, ":busy_g"}, 32'(busy), 32'd1);
    check({tag, ":valid_g"}, 32'(result_valid), 32'd0);
    if (drop_req) req = '0;
    tick();
    check({tag, ":gnt_e"}, 32'(gnt), 32'd0);
    check({tag, ":busy_e"}, 32'(busy), 32'd1);
    tick();
    check({tag, ":valid"}, 32'(result_valid), 32'd1);
    check({tag, ":result"}, 32'(result), 32'(exp_res));
    check({tag, ":id"}, 32'(result_id), 32'(lane));
    check({tag, ":busy_r"}, 32'(busy), 32'd1);
    tick();
    check({tag, ":valid_off"}, 32'(result_valid), 32'd0);
    check({tag, ":busy_off"}, 32'(busy), 32'd0);
    check({tag, ":hold"}, 32'(result), 32'(exp_res));
  endtask

  task automatic run_op(input int lane, input logic [3:0] data, input logic exp_res, input string tag);
    req      = NR'(1) << lane;
    req_data = '0;
    req_data[4*lane +: 4] = data;
    service(lane, exp_res, 1'b1, tag);
  endtask

  initial begin
    logic [7:0] stat_exp;
    int rr_ids [5];
    logic rr_res [4];

    rst_n = 1'b0;
    ena = 1'b1;
    req = '0;
    req_data = '0;

    // Reset values before any clock edge
    #2;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_id", 32'(result_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stat", 32'(stat_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_busy_gnt", 32'({busy, gnt}), 32'd0);
    end

    // Single request, lane 0, AND of 1,1
    run_op(0, 4'b0011, 1'b1, "single");

    // Opcode sweep on lane 2
    run_op(2, 4'b0001, 1'b0, "op_and");
    run_op(2, 4'b0101, 1'b1, "op_or");
    run_op(2, 4'b1001, 1'b1, "op_xor");
    run_op(2, 4'b1101, 1'b1, "op_nand10");
    run_op(2, 4'b1111, 1'b0, "op_nand11");

    // Lane 1 XOR(a=0,b=1)=1; data changed after sampling to a=1 (would give 0)
    req = 4'b0010;
    req_data = '0;
    req_data[7:4] = 4'b1010;
    tick();
    check("latch:gnt", 32'(gnt), 32'h2);
    req = '0;
    req_data[7:4] = 4'b1011;
    tick();
    req_data[7:4] = 4'b1011;
    tick();
    check("latch:valid", 32'(result_valid), 32'd1);
    check("latch:result", 32'(result), 32'd1);
    check("latch:id", 32'(result_id), 32'd1);
    tick();
    req_data = '0;

    // ena low for 3 cycles in GRANT, then for 1 cycle in RESP; lane 3 OR(1,0)=1
    req = 4'b1000;
    req_data[15:12] = 4'b0101;
    tick();
    ena = 1'b0;
    #1;
    check("ena:gnt_masked0", 32'(gnt), 32'd0);
    req = '0;
    tick();
    check("ena:gnt_masked1", 32'(gnt), 32'd0);
    check("ena:busy_frozen", 32'(busy), 32'd1);
    tick();
    check("ena:gnt_masked2", 32'(gnt), 32'd0);
    tick();
    ena = 1'b1;
    #1;
    check("ena:gnt_late", 32'(gnt), 32'h8);
    tick();
    check("ena:gnt_once", 32'(gnt), 32'd0);
    tick();
    ena = 1'b0;
    #1;
    check("ena:valid_masked", 32'(result_valid), 32'd0);
    tick();
    check("ena:valid_masked2", 32'(result_valid), 32'd0);
    ena = 1'b1;
    #1;
    check("ena:valid_late", 32'(result_valid), 32'd1);
    check("ena:result", 32'(result), 32'd1);
    check("ena:id", 32'(result_id), 32'd3);
    tick();
    check("ena:valid_once", 32'(result_valid), 32'd0);
    req_data = '0;

    // Asynchronous reset in EXEC: no result_valid for the lost operation
    req = 4'b0001;
    req_data[3:0] = 4'b0011;
    tick();
    req = '0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("rstx:busy", 32'(busy), 32'd0);
    check("rstx:result", 32'(result), 32'd0);
    check("rstx:id", 32'(result_id), 32'd0);
    check("rstx:valid", 32'(result_valid), 32'd0);
    // Keep all four requests pending across reset for the round-robin run
    req = 4'b1111;
    req_data = 16'hDB43;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstx:no_valid", 32'(result_valid), 32'd0);
    end
    rst_n = 1'b1;

    // Round robin: lanes 0..3 then 0 again; per-lane results from 16'hDB43
    rr_ids = '{0, 1, 2, 3, 0};
    rr_res = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      service(rr_ids[k], rr_res[rr_ids[k]], 1'b0, "rr");
    end

    // Pointer is now 1: lanes {0,3} -> lane 3 first, then wrap to lane 0
    req = 4'b1001;
    service(3, 1'b1, 1'b0, "wrap3");
    service(0, 1'b1, 1'b1, "wrap0");

    // Statistics counter
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 12; i++) tick();
`ifdef GATE_OP_STATS_EN
    stat_exp = 8'd3;
`else
    stat_exp = 8'd0;
`endif
    check("stat_3ops", 32'(stat_count), 32'(stat_exp));
    for (int i = 0; i < 1188; i++) tick();
`ifdef GATE_OP_STATS_EN
    stat_exp = 8'd255;
`else
    stat_exp = 8'd0;
`endif
    check("stat_300ops", 32'(stat_count), 32'(stat_exp));
    req = '0;
    for (int i = 0; i < 8; i++) tick();
    check("stat_hold", 32'(stat_count), 32'(stat_exp));
    check("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
